// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, one imem request outstanding, IF/ID update 1 edge after ack.
// Backpressure: decode freeze parks an acked word in hold_buf; taken branches squash IF/ID and redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] redir_pc;
   logic [31:0] hold_buf;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic        ack;

   assign br_target = {branch_addr[31:2], 2'b00};
   assign pc_plus4  = pc + 32'd4;

   // Request depends only on state and reset, never on freeze/branch_taken.
   assign imem_req  = rst && (state != S_HOLD);
   assign imem_addr = pc;
   assign ack       = imem_req && imem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         redir_pc <= 32'd0;
         hold_buf <= 32'd0;
         if_pc    <= 32'd0;
         if_instr <= NOP_INSTR;
         if_valid <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (ack) begin
                  if (branch_taken) begin
                     if_valid <= 1'b0;
                     if_instr <= NOP_INSTR;
                     pc       <= br_target;
                  end else if (freeze) begin
                     hold_buf <= imem_rdata;
                     state    <= S_HOLD;
                  end else begin
                     if_instr <= imem_rdata;
                     if_pc    <= pc_plus4;
                     if_valid <= 1'b1;
                     pc       <= pc_plus4;
                  end
               end else if (branch_taken) begin
                  // The in-flight request still completes; S_FLUSH swallows its data.
                  if_valid <= 1'b0;
                  if_instr <= NOP_INSTR;
                  redir_pc <= br_target;
                  state    <= S_FLUSH;
               end
            end
            S_HOLD: begin
               if (branch_taken) begin
                  if_valid <= 1'b0;
                  if_instr <= NOP_INSTR;
                  hold_buf <= 32'd0;
                  pc       <= br_target;
                  state    <= S_REQ;
               end else if (!freeze) begin
                  if_instr <= hold_buf;
                  if_pc    <= pc_plus4;
                  if_valid <= 1'b1;
                  pc       <= pc_plus4;
                  state    <= S_REQ;
               end
            end
            S_FLUSH: begin
               if (branch_taken) begin
                  redir_pc <= br_target;
                  if_valid <= 1'b0;
                  if_instr <= NOP_INSTR;
               end
               if (ack) begin
                  pc    <= branch_taken ? br_target : redir_pc;
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, hand-written reset/wrap sequence, randomized run vs. stream model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   // memory model state
   int unsigned wcnt = 0;
   int unsigned mem_wait = 0;
   logic        stray_ack = 1'b0;
   logic        hash_en = 1'b0;

   int total = 0;
   int bad   = 0;

   logic        p_req, p_ack, p_f, p_b, p_valid;
   logic [31:0] p_ba, p_addr, p_pc, p_instr;
   logic [31:0] exp_next;
   int          npres;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
      return h ? ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D) : a;
   endfunction

   assign imem_ack   = (imem_req && (wcnt >= mem_wait)) || stray_ack;
   assign imem_rdata = mem_word(imem_addr, hash_en);

   if_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .if_pc(if_pc),
      .if_instr(if_instr), .if_valid(if_valid)
   );

   typedef struct {
      logic        rs;
      int unsigned wt;
      logic        f;
      logic        b;
      logic [31:0] ba;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ei;
      logic        ereq;
      logic [31:0] ea;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rs, input int unsigned wt, input logic f, input logic b,
                               input logic [31:0] ba, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ei, input logic ereq, input logic [31:0] ea);
      vec_t v;
      v.rs = rs; v.wt = wt; v.f = f; v.b = b; v.ba = ba;
      v.ev = ev; v.epc = epc; v.ei = ei; v.ereq = ereq; v.ea = ea;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, NOP);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RPC);
   endtask

   // One clock: snapshot pre-edge values, take the edge, advance the memory wait counter.
   task automatic step();
      @(negedge clk);
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_f = freeze; p_b = branch_taken; p_ba = branch_addr;
      p_valid = if_valid; p_pc = if_pc; p_instr = if_instr;
      @(posedge clk);
      #1;
      if (!rst) wcnt = 0;
      else if (p_req && p_ack) wcnt = 0;
      else if (p_req) wcnt++;
   endtask

   task automatic do_reset();
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
      stray_ack = 1'b0; wcnt = 0;
      #1;
      chk_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      if (v.rs) do_reset();
      mem_wait = v.wt; freeze = v.f; branch_taken = v.b; branch_addr = v.ba;
      step();
      chk("vec_valid", {31'd0, if_valid}, {31'd0, v.ev});
      chk("vec_instr", if_instr, v.ei);
      if (v.ev) chk("vec_pc", if_pc, v.epc);
      chk("vec_req", {31'd0, imem_req}, {31'd0, v.ereq});
      chk("vec_addr", imem_addr, v.ea);
   endtask

   // Stream-level model: presented words form pc, pc+4, ... restarted at each branch target.
   task automatic rand_check();
      if (p_b) begin
         chk("br_flush_valid", {31'd0, if_valid}, 32'd0);
         chk("br_flush_instr", if_instr, NOP);
         exp_next = {p_ba[31:2], 2'b00} + 32'd4;
      end else begin
         chk("valid_drop", {31'd0, p_valid && !if_valid}, 32'd0);
         if (p_f) begin
            chk("frz_valid", {31'd0, if_valid}, {31'd0, p_valid});
            chk("frz_pc", if_pc, p_pc);
            chk("frz_instr", if_instr, p_instr);
         end else if (if_valid && (!p_valid || if_pc != p_pc)) begin
            npres++;
            chk("seq_pc", if_pc, exp_next);
            chk("seq_instr", if_instr, mem_word(if_pc - 32'd4, 1'b1));
            exp_next = if_pc + 32'd4;
         end
      end
      if (p_req && !p_ack) chk("addr_stable", imem_addr, p_addr);
   endtask

   initial begin
      // zero-wait stream from reset
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(k == 1, 0, 0, 0, 0, 1, 4*k, 4*k - 4, 1, 4*k));
      // freeze for 3 cycles on the ack of 0x10
      for (int k = 1; k <= 4; k++)
         tbl.push_back(mk(k == 1, 0, 0, 0, 0, 1, 4*k, 4*k - 4, 1, 4*k));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h10, 32'h0C, 0, 32'h10));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h14, 32'h10, 1, 32'h14));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h18, 32'h14, 1, 32'h18));
      // branch to 0x100 while 0x20 waits two cycles
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(k == 1, 0, 0, 0, 0, 1, 4*k, 4*k - 4, 1, 4*k));
      tbl.push_back(mk(0, 2, 0, 1, 32'h100, 0, 0, NOP, 1, 32'h20));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, NOP, 1, 32'h20));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, NOP, 1, 32'h100));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h104, 32'h100, 1, 32'h104));
      // two wait cycles per fetch
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, NOP, 1, 32'h0));
      tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, NOP, 1, 32'h0));
      for (int k = 1; k <= 2; k++)
         for (int r = 0; r < 3; r++)
            tbl.push_back(mk(0, 2, 0, 0, 0, 1, 4*k, 4*k - 4, 1, 4*k));
      tbl.push_back(mk(0, 2, 0, 0, 0, 1, 32'h0C, 32'h08, 1, 32'h0C));
      // branch and freeze together while holding
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h4, 32'h0, 1, 32'h4));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h4, 32'h0, 0, 32'h4));
      tbl.push_back(mk(0, 0, 1, 1, 32'h40, 0, 0, NOP, 1, 32'h40));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h44, 32'h40, 1, 32'h44));

      hash_en = 1'b0;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // async reset mid-wait, then PC wrap through 0xFFFF_FFFC
      apply(mk(1, 0, 0, 0, 0, 1, 32'h4, 32'h0, 1, 32'h4));
      apply(mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h4, 1, 32'h8));
      apply(mk(0, 0, 0, 0, 0, 1, 32'h0C, 32'h8, 1, 32'h0C));
      apply(mk(0, 2, 0, 0, 0, 1, 32'h0C, 32'h8, 1, 32'h0C));
      #3;
      rst = 1'b0;
      wcnt = 0;
      #1;
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(mk(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, NOP, 1, 32'hFFFF_FFFC));
      apply(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 1, 32'h0));

      // randomized run against the stream model
      hash_en = 1'b1;
      do_reset();
      exp_next = RPC + 32'd4;
      npres = 0;
      for (int c = 0; c < 3000; c++) begin
         freeze       = ($urandom % 4) == 0;
         branch_taken = ($urandom % 12) == 0;
         branch_addr  = $urandom;
         mem_wait     = $urandom % 3;
         stray_ack    = ($urandom % 5) == 0;
         step();
         rand_check();
      end
      chk("progress", {31'd0, npres > 300}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
